melody_sequencer: RTL
=====================

// Module: melody_sequencer
// PURPOSE
//   Sequences the piano tone generator. Plays one of two stored melodies as timed one-hot notes and
//   arbitrates with manual note switches (manual wins). Drives the 8-bit one-hot note bus that feeds
//   the tone-counter/octave register.
//   Replaces delay-based playback with a synthesizable ROM + beat-timer FSM on CLOCK_27.
// PARAMETERS
//   BEAT_CYCLES  6750000  CLOCK_27 cycles per beat (4 beats/s); must be > GAP_CYCLES+1
//   GAP_CYCLES   675000   silent cycles at end of every step (separates repeated notes); >=1
//   LOOP         0        1: restart melody after END entry; 0: stop in DONE
// PORTS
//   CLOCK_27      in   1  system clock, 27 MHz
//   Reset         in   1  asynchronous, active-low reset
//   song_sel      in   2  [1]=melody A (Twinkle), [0]=melody B (Jingle); [1] has priority if both set
//   manual_notes  in   8  one-hot manual keys (DO..DO1, bit0=DO); nonzero overrides the sequencer
//   notes         out  8  one-hot note to tone generator; 0 = silence
//   playing       out  1  1 while FSM is in LOAD/NOTE/GAP
//   song_done     out  1  one-cycle pulse when END entry is reached
//   step          out  6  ROM step index within the current melody
//   active_song   out  2  melody currently sequenced (one-hot as song_sel), 0 when IDLE
// BEHAVIOUR
//   Reset: notes=0, playing=0, song_done=0, step=0, active_song=0, state=IDLE, counters=0.
//   ROM entry 5 bits: [4:3] duration (0=1 beat, 1=2, 2=4, 3=END), [2:0] note index; notes = 1<<idx.
//   Melody A: DO DO SOL SOL LA LA SOL(2) FA FA MI MI RE RE DO(2) END.
//   Melody B: SI SI SI(2) SI SI SI(2) SI RE SOL LA SI(4) END.
//   States: IDLE, LOAD, NOTE, GAP, DONE. All outputs registered.
//   IDLE: song_sel!=0 sampled at cycle N -> LOAD at N+1 (active_song latched, step=0).
//   LOAD (1 cycle, notes=0): read ROM[step]; END -> song_done=1 same cycle, then LOAD step 0 if LOOP
//     else DONE; otherwise -> NOTE with notes=onehot(idx).
//   NOTE: lasts dur*BEAT_CYCLES-GAP_CYCLES-1 cycles -> GAP. GAP: notes=0 for GAP_CYCLES -> LOAD, step+1.
//   Step period is exactly dur*BEAT_CYCLES cycles (LOAD+NOTE+GAP).
//   DONE: notes=0, playing=0; hold until song_sel==0 -> IDLE.
//   Manual override: manual_notes!=0 -> notes=manual_notes next cycle; beat counter and FSM frozen.
//     On release, the sequencer resumes the same step with remaining count.
//     With song_sel==0, notes tracks manual_notes with 1-cycle latency.
//   Non-one-hot manual_notes are passed unchanged; the tone generator treats them as silence.
//   song_sel change while not IDLE/DONE: to 0 -> IDLE next cycle (notes=0, step=0).
//     To a different melody -> LOAD step 0 of the new melody next cycle.
//   Beat counter width $clog2(4*BEAT_CYCLES); it never wraps mid-note. step saturates at 63.
//   Reset assertion mid-melody: immediate return to reset values; no song_done pulse.
// TESTING (BEAT_CYCLES=8, GAP_CYCLES=2, LOOP=0)
//   Reset release, song_sel=0, manual_notes=0x04 -> notes=0x04 one cycle later; playing=0.
//   song_sel=2'b10 -> notes pattern 0,0x01x5,0x00x2,0,0x01x5,...; SOL(2) high 13 cycles;
//     song_done pulses after step 14; playing drops.
//   song_sel=2'b11 -> melody A chosen (active_song=2'b10); SI(4) in B holds 0x40 for 29 cycles.
//   During melody A step 2, hold manual_notes=0x80 for 20 cycles -> notes=0x80.
//     Release -> SOL resumes with its remaining cycles and step unchanged.
//   Mid-melody switch song_sel 2'b10->2'b01 -> next cycle LOAD, step=0, first note 0x40.
//   LOOP=1: after END, song_done pulses once and step returns to 0 without entering DONE.
//   Reset low during NOTE -> notes=0, playing=0, step=0 asynchronously.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - song select / manual key / note bus bundle for melody_sequencer
// Ports (slave = sequencer side):
//   song_sel      in   2  [1]=melody A, [0]=melody B, [1] wins when both set
//   manual_notes  in   8  manual keys, nonzero overrides the sequencer
//   notes         out  8  one-hot note to the tone generator, 0 = silence
//   playing       out  1  high while a melody step is being sequenced
//   song_done     out  1  one-cycle pulse on the END entry
//   step          out  6  ROM step index within the current melody
//   active_song   out  2  melody being sequenced, 0 when idle
interface melody_sequencer_if;
    logic [1:0] song_sel;
    logic [7:0] manual_notes;
    logic [7:0] notes;
    logic       playing;
    logic       song_done;
    logic [5:0] step;
    logic [1:0] active_song;

    modport master (
        output song_sel, manual_notes,
        input  notes, playing, song_done, step, active_song
    );

    modport slave (
        input  song_sel, manual_notes,
        output notes, playing, song_done, step, active_song
    );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - ROM + beat-timer melody sequencer with manual key override
// Purpose: plays one of two stored melodies as timed one-hot notes on the note bus feeding
//   the tone generator; a nonzero manual key pattern overrides and freezes the sequencer.
// Ports:
//   CLOCK_27  in  1  system clock
//   Reset     in  1  asynchronous active-low reset
//   bus       slave modport of melody_sequencer_if (song_sel, manual_notes in;
//             notes, playing, song_done, step, active_song out)
module melody_sequencer #(
    parameter int BEAT_CYCLES = 6750000,
    parameter int GAP_CYCLES  = 675000,
    parameter int LOOP        = 0
) (
    input  logic               CLOCK_27,
    input  logic               Reset,
    melody_sequencer_if.slave  bus
);

    localparam int CW = $clog2(4 * BEAT_CYCLES);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    // ROM entry: [4:3] duration code, [2:0] note index
    localparam logic [1:0] D1    = 2'd0;
    localparam logic [1:0] D2    = 2'd1;
    localparam logic [1:0] D4    = 2'd2;
    localparam logic [1:0] D_END = 2'd3;

    localparam logic [2:0] N_DO  = 3'd0;
    localparam logic [2:0] N_RE  = 3'd1;
    localparam logic [2:0] N_MI  = 3'd2;
    localparam logic [2:0] N_FA  = 3'd3;
    localparam logic [2:0] N_SOL = 3'd4;
    localparam logic [2:0] N_LA  = 3'd5;
    localparam logic [2:0] N_SI  = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP, S_DONE} state_t;

    // Melody B (Jingle) when song==2'b01, otherwise melody A (Twinkle).
    // Anything past the last note reads as END so a runaway step still terminates.
    function automatic logic [4:0] rom_entry(input logic [1:0] song, input logic [5:0] idx);
        logic [4:0] e;
        e = {D_END, N_DO};
        if (song == 2'b01) begin
            case (idx)
                6'd0:  e = {D1, N_SI};
                6'd1:  e = {D1, N_SI};
                6'd2:  e = {D2, N_SI};
                6'd3:  e = {D1, N_SI};
                6'd4:  e = {D1, N_SI};
                6'd5:  e = {D2, N_SI};
                6'd6:  e = {D1, N_SI};
                6'd7:  e = {D1, N_RE};
                6'd8:  e = {D1, N_SOL};
                6'd9:  e = {D1, N_LA};
                6'd10: e = {D4, N_SI};
                default: e = {D_END, N_DO};
            endcase
        end else begin
            case (idx)
                6'd0:  e = {D1, N_DO};
                6'd1:  e = {D1, N_DO};
                6'd2:  e = {D1, N_SOL};
                6'd3:  e = {D1, N_SOL};
                6'd4:  e = {D1, N_LA};
                6'd5:  e = {D1, N_LA};
                6'd6:  e = {D2, N_SOL};
                6'd7:  e = {D1, N_FA};
                6'd8:  e = {D1, N_FA};
                6'd9:  e = {D1, N_MI};
                6'd10: e = {D1, N_MI};
                6'd11: e = {D1, N_RE};
                6'd12: e = {D1, N_RE};
                6'd13: e = {D2, N_DO};
                default: e = {D_END, N_DO};
            endcase
        end
        return e;
    endfunction

    function automatic logic [1:0] rom_dur(input logic [1:0] song, input logic [5:0] idx);
        logic [4:0] e;
        e = rom_entry(song, idx);
        return e[4:3];
    endfunction

    // Last counter value of the NOTE phase; LOAD (1) + NOTE + GAP adds up to the full step.
    function automatic logic [CW-1:0] note_last(input logic [1:0] dur);
        logic [CW-1:0] v;
        case (dur)
            D1:      v = CW'(BEAT_CYCLES - GAP_CYCLES - 2);
            D2:      v = CW'(2 * BEAT_CYCLES - GAP_CYCLES - 2);
            default: v = CW'(4 * BEAT_CYCLES - GAP_CYCLES - 2);
        endcase
        return v;
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    active_q, active_d;
    logic [7:0]    notes_q, notes_d;
    logic          playing_q, playing_d;
    logic          done_q, done_d;

    logic          frozen;
    logic [1:0]    sel_oh;
    logic [1:0]    cur_dur;
    logic [4:0]    nxt_entry;

    assign frozen  = (bus.manual_notes != 8'h00);
    assign sel_oh  = bus.song_sel[1] ? 2'b10 : (bus.song_sel[0] ? 2'b01 : 2'b00);
    assign cur_dur = rom_dur(active_q, step_q);

    always_ff @(posedge CLOCK_27 or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            notes_q   <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            notes_q   <= notes_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    // Manual keys freeze everything, so the interrupted step resumes with its remaining count.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (!frozen) begin
            case (state_q)
                S_IDLE: begin
                    if (sel_oh != 2'b00) begin
                        state_d  = S_LOAD;
                        active_d = sel_oh;
                        step_d   = '0;
                        cnt_d    = '0;
                    end
                end
                S_LOAD, S_NOTE, S_GAP: begin
                    if (sel_oh == 2'b00) begin
                        state_d  = S_IDLE;
                        step_d   = '0;
                        cnt_d    = '0;
                        active_d = 2'b00;
                    end else if (sel_oh != active_q) begin
                        state_d  = S_LOAD;
                        step_d   = '0;
                        cnt_d    = '0;
                        active_d = sel_oh;
                    end else begin
                        case (state_q)
                            S_LOAD: begin
                                if (cur_dur == D_END) begin
                                    if (LOOP != 0) begin
                                        state_d = S_LOAD;
                                        step_d  = '0;
                                    end else begin
                                        state_d = S_DONE;
                                    end
                                end else begin
                                    state_d = S_NOTE;
                                    cnt_d   = note_last(cur_dur);
                                end
                            end
                            S_NOTE: begin
                                if (cnt_q == '0) begin
                                    state_d = S_GAP;
                                    cnt_d   = GAP_LAST;
                                end else begin
                                    cnt_d = cnt_q - CW'(1);
                                end
                            end
                            S_GAP: begin
                                if (cnt_q == '0) begin
                                    state_d = S_LOAD;
                                    step_d  = (step_q == 6'd63) ? 6'd63 : step_q + 6'd1;
                                end else begin
                                    cnt_d = cnt_q - CW'(1);
                                end
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
                S_DONE: begin
                    if (bus.song_sel == 2'b00) begin
                        state_d  = S_IDLE;
                        step_d   = '0;
                        active_d = 2'b00;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so the registers line up with the state they describe.
    always_comb begin
        nxt_entry = rom_entry(active_d, step_d);
        notes_d   = 8'h00;
        if (frozen) begin
            notes_d = bus.manual_notes;
        end else if (state_d == S_NOTE) begin
            notes_d = 8'h01 << nxt_entry[2:0];
        end
        playing_d = (state_d == S_LOAD) || (state_d == S_NOTE) || (state_d == S_GAP);
        // Pulse only on the cycle LOAD reaches END, not again while a key holds LOAD frozen.
        done_d    = !frozen && (state_d == S_LOAD) && (nxt_entry[4:3] == D_END);
    end

    assign bus.notes       = notes_q;
    assign bus.playing     = playing_q;
    assign bus.song_done   = done_q;
    assign bus.step        = step_q;
    assign bus.active_song = active_q;

endmodule
